// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Brief    : Op encodings, FSM states and iteration count for muldiv_seq.
// Revision : 1.0
// ============================================================================
package muldiv_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = $clog2(ITER_COUNT);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        NEG_A  = 3'd1,
        NEG_B  = 3'd2,
        ITER   = 3'd3,
        FIX_LO = 3'd4,
        FIX_HI = 3'd5,
        DONE   = 3'd6
    } state_t;

    function automatic logic op_is_signed(input logic [1:0] o);
        return o[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder32.sv
`default_nettype none
// ============================================================================
// Module   : adder32
// Brief    : 32-bit carry-lookahead adder, 4-bit lookahead groups chained.
// Revision : 1.0
// ============================================================================
module adder32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
    input  logic        sign_i,
    output logic [31:0] sum_o,
    output logic        cout_o,
    output logic        v_o
);

    logic [31:0] w_g;
    logic [31:0] w_p;
    logic [31:0] w_c;
    logic [8:0]  w_gc;

    assign w_g = a_i & b_i;
    assign w_p = a_i ^ b_i;

    always_comb begin
        w_c     = '0;
        w_gc    = '0;
        w_gc[0] = cin_i;
        for (int k = 0; k < 8; k++) begin
            w_c[4*k]   = w_gc[k];
            w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_gc[k]);
            w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+1] & w_p[4*k] & w_gc[k]);
            w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_gc[k]);
            w_gc[k+1]  = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2])
                       | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_gc[k]);
        end
    end

    assign sum_o  = w_p ^ w_c;
    assign cout_o = w_gc[8];
    // Signed mode reports two's-complement overflow; unsigned mode reports carry.
    assign v_o    = sign_i ? (w_gc[8] ^ w_c[31]) : w_gc[8];

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq
// Brief    : Iterative 32-bit MULTU/MULT/DIVU/DIV on one shared adder, 37 cycles.
//            Divide support is built only when MULDIV_DIV_EN is defined.
// Revision : 1.0
// ============================================================================
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   bmag_q, bmag_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [WIDTH-1:0]   add_a, add_b, add_sum;
    logic               add_cin, add_cout, add_v;

`ifdef MULDIV_DIV_EN
    logic [WIDTH-1:0]   w_rem_sh;
    logic               w_qbit;

    assign w_rem_sh = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
    // A remainder MSB shifted out means the 33-bit partial remainder exceeds Bmag.
    assign w_qbit   = hi_q[WIDTH-1] | add_v;
`endif

    adder32 u_adder32 (
        .a_i    (add_a),
        .b_i    (add_b),
        .cin_i  (add_cin),
        .sign_i (1'b0),
        .sum_o  (add_sum),
        .cout_o (add_cout),
        .v_o    (add_v)
    );

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        case (state_q)
            NEG_A: begin
                add_b   = ~lo_q;
                add_cin = 1'b1;
            end
            NEG_B: begin
                add_b   = ~bmag_q;
                add_cin = 1'b1;
            end
            ITER: begin
`ifdef MULDIV_DIV_EN
                if (op_q[1]) begin
                    add_a   = w_rem_sh;
                    add_b   = ~bmag_q;
                    add_cin = 1'b1;
                end else
`endif
                begin
                    add_a = hi_q;
                    add_b = lo_q[0] ? bmag_q : '0;
                end
            end
            FIX_LO: begin
                add_b   = ~lo_q;
                add_cin = 1'b1;
            end
            FIX_HI: begin
                add_b   = ~hi_q;
`ifdef MULDIV_DIV_EN
                add_cin = op_q[1] ? 1'b1 : carry_q;
`else
                add_cin = carry_q;
`endif
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        bmag_d  = bmag_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    hi_d    = '0;
                    lo_d    = A;
                    bmag_d  = B;
                    sa_d    = op_is_signed(op) & A[WIDTH-1];
                    sb_d    = op_is_signed(op) & B[WIDTH-1];
                    cnt_d   = '0;
                    state_d = NEG_A;
`ifndef MULDIV_DIV_EN
                    if (op[1]) begin
                        lo_d    = '0;
                        sa_d    = 1'b0;
                        sb_d    = 1'b0;
                        state_d = DONE;
                    end
`endif
                end
            end
            NEG_A: begin
                if (sa_q) lo_d = add_sum;
                state_d = NEG_B;
            end
            NEG_B: begin
                if (sb_q) bmag_d = add_sum;
                state_d = ITER;
            end
            ITER: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITER_COUNT - 1)) state_d = FIX_LO;
`ifdef MULDIV_DIV_EN
                if (op_q[1]) begin
                    hi_d = w_qbit ? add_sum : w_rem_sh;
                    lo_d = {lo_q[WIDTH-2:0], w_qbit};
                end else
`endif
                begin
                    hi_d = {add_v, add_sum[WIDTH-1:1]};
                    lo_d = {add_sum[0], lo_q[WIDTH-1:1]};
                end
            end
            FIX_LO: begin
                state_d = FIX_HI;
`ifdef MULDIV_DIV_EN
                // Divide by zero keeps the all-ones quotient untouched.
                if (op_q[1]) begin
                    if ((sa_q ^ sb_q) && (bmag_q != '0)) lo_d = add_sum;
                end else
`endif
                if ((op_q == OP_MULT) && (sa_q ^ sb_q)) begin
                    lo_d    = add_sum;
                    carry_d = add_cout;
                end
            end
            FIX_HI: begin
                state_d = DONE;
`ifdef MULDIV_DIV_EN
                if (op_q[1]) begin
                    if (sa_q) hi_d = add_sum;
                end else
`endif
                if ((op_q == OP_MULT) && (sa_q ^ sb_q)) hi_d = add_sum;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            bmag_q  <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            bmag_q  <= bmag_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q != IDLE) && (state_q != DONE);
    assign done = (state_q == DONE);
    assign Hi   = hi_q;
    assign Lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_seq
// Brief    : Self-checking bench for muldiv_seq (vector table + scoreboard).
// Revision : 1.0
// ============================================================================
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        busy, done;

    int nerr = 0;
    int nchk = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] sb_q[$];
    int          lat_q[$];

    always #5 clk = ~clk;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .A       (a),
        .B       (b),
        .busy    (busy),
        .done    (done),
        .Hi      (hi),
        .Lo      (lo)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int lat_of(input logic [1:0] o);
`ifdef MULDIV_DIV_EN
        return 37;
`else
        return o[1] ? 1 : 37;
`endif
    endfunction

    // Divide expectations collapse to zero when the divider is not built.
    function automatic logic [63:0] dexp(input logic [63:0] v);
`ifdef MULDIV_DIV_EN
        return v;
`else
        return 64'h0;
`endif
    endfunction

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sp;
`ifdef MULDIV_DIV_EN
        logic signed [31:0] sq, sr;
`endif
        case (o)
            OP_MULTU: return {32'h0, x} * {32'h0, y};
            OP_MULT: begin
                sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
                return sp;
            end
            default: begin
`ifdef MULDIV_DIV_EN
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                if (o == OP_DIVU) return {x % y, x / y};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                sq = $signed(x) / $signed(y);
                sr = $signed(x) % $signed(y);
                return {sr, sq};
`else
                return 64'h0;
`endif
            end
        endcase
    endfunction

    function automatic vec_t mk(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                input logic [63:0] e);
        vec_t v;
        v.op  = o;
        v.a   = x;
        v.b   = y;
        v.exp = e;
        v.lat = lat_of(o);
        return v;
    endfunction

    task automatic drive(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] e, input int l, input bit push);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (push) begin
            sb_q.push_back(e);
            lat_q.push_back(l);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = ~o;
        a     = $urandom;
        b     = $urandom;
    endtask

    // Entered #1 after the edge of cycle t+cyc0; returns in the DONE cycle.
    task automatic wait_done(input int cyc0, input bit chk_busy);
        int          cyc;
        int          bcnt;
        logic [63:0] e;
        int          el;
        cyc  = cyc0;
        bcnt = 0;
        while (done !== 1'b1 && cyc < 120) begin
            if (busy === 1'b1) bcnt++;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (sb_q.size() == 0) begin
            nchk++;
            nerr++;
            $display("FAIL scoreboard: done seen with no queued expectation");
            return;
        end
        e  = sb_q.pop_front();
        el = lat_q.pop_front();
        chk("latency", 64'(cyc), 64'(el));
        chk("busy_at_done", {63'h0, busy}, 64'h0);
        if (chk_busy) chk("busy_cycles", 64'(bcnt), 64'(el - 1));
        chk("result", {hi, lo}, e);
    endtask

    task automatic run_op(input vec_t v);
        drive(v.op, v.a, v.b, v.exp, v.lat, 1'b1);
        wait_done(1, 1'b1);
        @(posedge clk);
        #1;
        chk("done_one_pulse", {63'h0, done}, 64'h0);
        chk("hold_after_done", {hi, lo}, v.exp);
    endtask

    initial begin
        int          ndone;
        logic [1:0]  ro;
        logic [31:0] rx, ry;

        reset_n = 1'b0;
        start   = 1'b0;
        op      = 2'b00;
        a       = '0;
        b       = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {63'h0, busy}, 64'h0);
        chk("reset_done", {63'h0, done}, 64'h0);
        chk("reset_hilo", {hi, lo}, 64'h0);
        reset_n = 1'b1;

        vecs.push_back(mk(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001));
        vecs.push_back(mk(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1));
        vecs.push_back(mk(OP_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000));
        vecs.push_back(mk(OP_MULTU, 32'h0000_0003, 32'h0000_0004, 64'h0000_0000_0000_000C));
        vecs.push_back(mk(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, dexp(64'hFFFF_FFFF_FFFF_FFFD)));
        vecs.push_back(mk(OP_DIVU,  32'h0000_0007, 32'h0000_0000, dexp(64'h0000_0007_FFFF_FFFF)));
        vecs.push_back(mk(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, dexp(64'h0000_0000_8000_0000)));
        vecs.push_back(mk(OP_DIVU,  32'd100,       32'd7,         dexp(64'h0000_0002_0000_000E)));
        vecs.push_back(mk(OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, dexp(64'h0000_0001_FFFF_FFFD)));
        vecs.push_back(mk(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, dexp(64'hFFFF_FFF9_FFFF_FFFF)));
        for (int i = 0; i < 8; i++) begin
            ro = 2'(i % 4);
            rx = $urandom;
            ry = (i >= 4) ? 32'($urandom_range(1, 5000)) : $urandom;
            vecs.push_back(mk(ro, rx, ry, model(ro, rx, ry)));
        end

        foreach (vecs[i]) run_op(vecs[i]);

        // A start raised in the DONE cycle is ignored; the following cycle accepts it.
        drive(OP_MULTU, 32'd3, 32'd4, 64'd12, 37, 1'b1);
        wait_done(1, 1'b1);
        start = 1'b1;
        op    = OP_MULTU;
        a     = 32'd5;
        b     = 32'd6;
        @(posedge clk);
        #1;
        chk("start_in_done_ignored", {63'h0, busy}, 64'h0);
        chk("hold_in_idle", {hi, lo}, 64'd12);
        sb_q.push_back(64'd30);
        lat_q.push_back(37);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(1, 1'b1);
        @(posedge clk);
        #1;

        // A second start mid-operation must not disturb the running MULT.
        drive(OP_MULT, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 37, 1'b1);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        op    = OP_MULTU;
        a     = 32'd7;
        b     = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(11, 1'b0);
        @(posedge clk);
        #1;

        // Reset asserted at t+20 aborts the operation without a done pulse.
`ifdef MULDIV_DIV_EN
        drive(OP_DIVU, 32'd100, 32'd7, 64'h0, 37, 1'b0);
`else
        drive(OP_MULTU, 32'd100, 32'd7, 64'h0, 37, 1'b0);
`endif
        ndone = 0;
        repeat (18) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) ndone++;
        end
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy", {63'h0, busy}, 64'h0);
        chk("abort_hilo", {hi, lo}, 64'h0);
        reset_n = 1'b1;
        repeat (45) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'h0);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
`default_nettype wire
